// File: rtl/leb128_fetch_pkg.sv
// Shared definitions for the LEB128 immediate fetch unit:
// FSM states, trap codes and per-width encoding limits.
package leb128_fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DECODE,
      ST_DONE
   } state_t;

   localparam logic [3:0] TRAP_NONE         = 4'd0;
   localparam logic [3:0] TRAP_MEM          = 4'd1;
   localparam logic [3:0] TRAP_LEB_OVERLONG = 4'd2;
   localparam logic [3:0] TRAP_NO_64B       = 4'd3;

   localparam logic [3:0] MAXLEN_32 = 4'd5;
   localparam logic [3:0] MAXLEN_64 = 4'd10;

   function automatic logic [3:0] maxlen(input logic is_64);
      return is_64 ? MAXLEN_64 : MAXLEN_32;
   endfunction

endpackage

// File: rtl/leb128_fetch_step.sv
// One LEB128 byte: merge 7 payload bits at position 7k, and on the
// terminating byte apply optional sign extension and width masking.
module leb128_step (
   input  logic [63:0] i_acc,
   input  logic [7:0]  i_byte,
   input  logic [3:0]  i_k,
   input  logic        i_signed,
   input  logic        i_is64,
   output logic [63:0] o_acc,
   output logic        o_term
);

   logic [6:0]  w_shift;
   logic [6:0]  w_bits;
   logic [6:0]  w_width;
   logic [63:0] w_part;
   logic [63:0] w_sum;
   logic [63:0] w_fill;
   logic [63:0] w_ext;

   always_comb begin
      w_shift = {3'b000, i_k} * 7'd7;
      w_bits  = w_shift + 7'd7;
      w_width = i_is64 ? 7'd64 : 7'd32;
      w_part  = {57'b0, i_byte[6:0]} << w_shift;
      w_sum   = i_acc | w_part;
      w_fill  = ~64'b0 << w_bits;
      o_term  = ~i_byte[7];
      w_ext   = w_sum;
      if (o_term && i_signed && i_byte[6] && (w_bits < w_width))
         w_ext = w_sum | w_fill;
      // payload bits landing above the result width are dropped here
      o_acc = i_is64 ? w_ext : {32'b0, w_ext[31:0]};
   end

endmodule

// File: rtl/leb128_fetch.sv
// LEB128 immediate fetch: reads a byte window from ROM and decodes a
// signed/unsigned 32/64-bit immediate one byte per cycle.
import leb128_fetch_pkg::*;

module leb128_fetch #(
   parameter int MEM_DEPTH = 4,
   parameter int MEM_EXTRA = 4,
   parameter bit USE_64B   = 1'b1
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_start,
   input  logic [MEM_DEPTH:0]       i_pc,
   input  logic                     i_is_signed,
   input  logic                     i_is_64,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [63:0]              o_value,
   output logic [3:0]               o_length,
   output logic [MEM_DEPTH:0]       o_next_pc,
   output logic [3:0]               o_trap,
   output logic [MEM_DEPTH:0]       o_mem_addr,
   output logic [MEM_EXTRA-1:0]     o_mem_extra,
   input  logic [(2**MEM_EXTRA)*8-1:0] i_mem_data,
   input  logic                     i_mem_error
);

   localparam int AW    = MEM_DEPTH + 1;
   localparam int WIN_W = (2**MEM_EXTRA) * 8;

   state_t           r_state;
   state_t           w_state_nx;
   logic [AW-1:0]    r_pc;
   logic             r_signed;
   logic             r_is64;
   logic [WIN_W-1:0] r_win;
   logic [63:0]      r_acc;
   logic [3:0]       r_k;
   logic [63:0]      r_value;
   logic [3:0]       r_length;
   logic [AW-1:0]    r_next_pc;
   logic [3:0]       r_trap;

   logic [3:0]       w_maxlen;
   logic             w_no64;
   logic             w_last;
   logic [3:0]       w_len;
   logic [63:0]      w_acc_nx;
   logic             w_term;

   assign w_maxlen = maxlen(r_is64);
   assign w_no64   = r_is64 && !USE_64B;
   assign w_last   = (r_k == w_maxlen - 4'd1);
   assign w_len    = r_k + 4'd1;

   leb128_step u_step (
      .i_acc    (r_acc),
      .i_byte   (r_win[7:0]),
      .i_k      (r_k),
      .i_signed (r_signed),
      .i_is64   (r_is64),
      .o_acc    (w_acc_nx),
      .o_term   (w_term)
   );

   always_comb begin
      w_state_nx  = r_state;
      o_mem_addr  = '0;
      o_mem_extra = '0;
      unique case (r_state)
         ST_IDLE:   if (i_start) w_state_nx = ST_REQ;
         ST_REQ: begin
            if (w_no64) begin
               w_state_nx = ST_DONE;
            end else begin
               w_state_nx  = ST_WAIT;
               o_mem_addr  = r_pc;
               o_mem_extra = MEM_EXTRA'(w_maxlen - 4'd1);
            end
         end
         ST_WAIT:   w_state_nx = i_mem_error ? ST_DONE : ST_DECODE;
         ST_DECODE: if (w_term || w_last) w_state_nx = ST_DONE;
         ST_DONE:   w_state_nx = ST_IDLE;
         default:   w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_pc      <= '0;
         r_signed  <= 1'b0;
         r_is64    <= 1'b0;
         r_win     <= '0;
         r_acc     <= '0;
         r_k       <= '0;
         r_value   <= '0;
         r_length  <= '0;
         r_next_pc <= '0;
         r_trap    <= TRAP_NONE;
      end else begin
         r_state <= w_state_nx;
         unique case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_pc     <= i_pc;
                  r_signed <= i_is_signed;
                  r_is64   <= i_is_64;
                  r_acc    <= '0;
                  r_k      <= '0;
               end
            end
            ST_REQ: begin
               if (w_no64) begin
                  r_value   <= '0;
                  r_length  <= '0;
                  r_next_pc <= r_pc;
                  r_trap    <= TRAP_NO_64B;
               end
            end
            ST_WAIT: begin
               r_win <= i_mem_data;
               if (i_mem_error) begin
                  r_value   <= '0;
                  r_length  <= '0;
                  r_next_pc <= r_pc;
                  r_trap    <= TRAP_MEM;
               end
            end
            ST_DECODE: begin
               r_acc <= w_acc_nx;
               r_win <= r_win >> 8;
               r_k   <= w_len;
               if (w_term) begin
                  r_value   <= w_acc_nx;
                  r_length  <= w_len;
                  r_next_pc <= r_pc + AW'(w_len);
                  r_trap    <= TRAP_NONE;
               end else if (w_last) begin
                  r_value   <= '0;
                  r_length  <= '0;
                  r_next_pc <= r_pc;
                  r_trap    <= TRAP_LEB_OVERLONG;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy    = (r_state != ST_IDLE);
   assign o_done    = (r_state == ST_DONE);
   assign o_value   = r_value;
   assign o_length  = r_length;
   assign o_next_pc = r_next_pc;
   assign o_trap    = r_trap;

endmodule

// File: doc/leb128_fetch.md
LEB128_FETCH -- requirements
Module: leb128_fetch

Interface
REQ-001 Parameter MEM_DEPTH, default 4: ROM address width; mem_addr is MEM_DEPTH+1 bits.
REQ-002 Parameter MEM_EXTRA, default 4: ROM window-size field width; mem_data is 2**MEM_EXTRA*8 bits.
REQ-003 Parameter USE_64B, default 1: enables 64-bit immediate decode.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  request a decode; accepted only when busy=0.
REQ-007 pc  in  MEM_DEPTH+1  byte address of the first LEB128 byte; sampled with start.
REQ-008 is_signed  in  1  signed LEB128 when 1; sampled with start.
REQ-009 is_64  in  1  64-bit immediate when 1, else 32-bit; sampled with start.
REQ-010 busy  out  1  high from the cycle after start is accepted until done.
REQ-011 done  out  1  one-cycle pulse; value, length, next_pc and trap are valid in that cycle and held until the next accepted start.
REQ-012 value  out  64  decoded immediate.
REQ-013 length  out  4  number of encoded bytes consumed.
REQ-014 next_pc  out  MEM_DEPTH+1  pc+length, modulo 2**(MEM_DEPTH+1).
REQ-015 trap  out  4  0 = none, else a trap code from the shared package.
REQ-016 mem_addr  out  MEM_DEPTH+1  ROM read address.
REQ-017 mem_extra  out  MEM_EXTRA  additional bytes requested; window = mem_extra+1 bytes.
REQ-018 mem_data  in  2**MEM_EXTRA*8  ROM window; byte i is mem_data[8i+7:8i] = ROM[mem_addr+i]; registered, valid one cycle after the request.
REQ-019 mem_error  in  1  ROM bound violation, aligned with mem_data.

Function
REQ-020 States: IDLE, REQ, WAIT, DECODE, DONE.
- IDLE: start=1 latches pc, is_signed and is_64 -> REQ.
- REQ: drives mem_addr=pc_q and mem_extra=MAXLEN-1 -> WAIT.
- WAIT: captures mem_data into a window register and mem_error -> DECODE.
- DECODE: consumes one byte per cycle.
- DONE: pulses done -> IDLE.
REQ-021 MAXLEN: 5 for 32-bit, 10 for 64-bit; mem_addr and mem_extra are 0 outside REQ.
REQ-022 DECODE per byte k: acc |= byte[6:0] << 7k; a byte with bit7=0 terminates, setting length=k+1.
REQ-023 Signed termination: if bit6 of the final byte is 1 and 7*length < width, acc is sign-extended to width.
REQ-024 Width rules:
- 32-bit results place the two's-complement value in value[31:0] with value[63:32]=0.
- Bits beyond width are discarded.
REQ-025 Latency: done asserts exactly length+3 cycles after the start cycle.
REQ-026 Trap conditions; on any trap, value=0 and length=0:
- mem_error captured in WAIT: TRAP_MEM; DECODE is skipped and the block goes to DONE.
- No terminator within MAXLEN bytes: TRAP_LEB_OVERLONG.
- is_64=1 with USE_64B=0: TRAP_NO_64B, raised at REQ with no ROM request.
REQ-027 start while busy=1 is ignored; start in the DONE cycle is ignored.
REQ-028 pc near the top of the address space wraps; next_pc wraps modulo 2**(MEM_DEPTH+1).

Reset
REQ-029 reset forces IDLE and clears busy, done, value, length, next_pc, trap, the window register and the accumulator to 0, including mid-decode.
REQ-030 reset has priority over start in the same cycle.

Structure
REQ-031 Trap codes TRAP_MEM, TRAP_LEB_OVERLONG and TRAP_NO_64B, the state enum and the MAXLEN constants belong in the shared core package.
REQ-032 A single sub-module, leb128_step, is natural: a combinational byte accumulate/sign-extend step. All other logic is flat.

Verification
REQ-033 Bytes 05, unsigned, 32-bit, start at cycle 0 -> done at cycle 4; value=5, length=1, next_pc=pc+1, trap=0.
REQ-034 Bytes E5 8E 26, unsigned, 32-bit -> value=0x98765, length=3, done 6 cycles after start.
REQ-035 Bytes 7F, signed, 32-bit -> value=0x00000000FFFFFFFF; bytes C0 BB 78, signed, 64-bit -> value=0xFFFFFFFFFFFE1DC0, length=3.
REQ-036 Six bytes 80 80 80 80 80 00, 32-bit -> trap=TRAP_LEB_OVERLONG, value=0; mem_error=1 -> trap=TRAP_MEM.
REQ-037 reset asserted during DECODE of a 3-byte encoding -> next cycle busy=0 and done=0; a new start decodes correctly.
REQ-038 pc=0x1F with MEM_DEPTH=4 and a 2-byte encoding -> next_pc=0x01; start pulsed while busy -> no second done.
